sid_spi_host: RTL

- Host-side SPI initiator that issues register write and read frames to the synth's SPI register port: 16-bit frames, mode 0, chip select active low.
- Sits in the FPGA/test-harness host logic, or in a sequencer block driving the synth over `sclk`/`cs`/`mosi`/`miso`. It converts a single-word valid/ready request into one complete frame and returns the read byte.

---
 rtl/sid_spi_host.sv | 101 ++++++++++
 1 files changed

// File: rtl/sid_spi_host.sv
// sid_spi_host: SPI mode-0 initiator that turns one valid/ready request into a
// 16-bit register write/read frame and returns the captured read byte.
module sid_spi_host #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_we_i,
   input  logic [6:0] req_addr_i,
   input  logic [7:0] req_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       busy_o,
   output logic       sclk_o,
   output logic       cs_o,
   output logic       mosi_o,
   input  logic       miso_i
);
   localparam int CW = $clog2(CLK_DIV);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_cnt;
   logic [15:0]   sh;
   logic [7:0]    cap;
   logic [1:0]    miso_sync;
   logic          we_q;
   logic          high;
   logic          last;
   assign last = cnt == CW'(CLK_DIV - 1);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         sh          <= '0;
         cap         <= '0;
         miso_sync   <= '0;
         we_q        <= 1'b0;
         high        <= 1'b0;
         req_ready_o <= 1'b1;
         busy_o      <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         sclk_o      <= 1'b0;
         cs_o        <= 1'b1;
         mosi_o      <= 1'b0;
      end else begin
         miso_sync   <= {miso_sync[0], miso_i};
         rsp_valid_o <= 1'b0;
         cnt         <= (state == IDLE || last) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (req_valid_i && req_ready_o) begin
               sh          <= {req_we_i, req_addr_i, req_we_i ? req_wdata_i : 8'h00};
               we_q        <= req_we_i;
               mosi_o      <= req_we_i;
               cs_o        <= 1'b0;
               req_ready_o <= 1'b0;
               busy_o      <= 1'b1;
               state       <= SETUP;
            end
            SETUP: if (last) begin
               state   <= SHIFT;
               bit_cnt <= 4'd15;
               high    <= 1'b0;
            end
            SHIFT: if (last) begin
               if (!high) begin
                  high   <= 1'b1;
                  sclk_o <= 1'b1;
               end else begin
                  // sample the synchronized miso at the end of the high phase
                  high   <= 1'b0;
                  sclk_o <= 1'b0;
                  cap    <= {cap[6:0], miso_sync[1]};
                  if (bit_cnt == 4'd0) state <= HOLD;
                  else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     sh      <= {sh[14:0], 1'b0};
                     mosi_o  <= sh[14];
                  end
               end
            end
            HOLD: if (last) begin
               state       <= GAP;
               cs_o        <= 1'b1;
               rsp_valid_o <= 1'b1;
               if (!we_q) rsp_rdata_o <= cap;
            end
            GAP: if (last) begin
               state       <= IDLE;
               req_ready_o <= 1'b1;
               busy_o      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
